// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Phase encoding and default 640x480@60 timing for the VGA
//               timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   typedef enum logic [1:0] {
      SYNC        = 2'b00,
      BACK_PORCH  = 2'b01,
      DISPLAY     = 2'b11,
      FRONT_PORCH = 2'b10
   } phase_t;

   localparam int c_H_ACTIVE = 640;
   localparam int c_H_FP     = 16;
   localparam int c_H_SYNC   = 96;
   localparam int c_H_BP     = 48;
   localparam int c_V_ACTIVE = 480;
   localparam int c_V_FP     = 10;
   localparam int c_V_SYNC   = 2;
   localparam int c_V_BP     = 33;
   localparam int c_PIX_DIV  = 4;

   // Counter width that stays legal when a range holds a single value.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_fsm
// Description : One timing axis: position counter plus SYNC/BP/DISPLAY/FP
//               phase machine with registered sync, active and position.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_fsm
   import vga_timing_pkg::*;
#(
   parameter int SYNC_LEN = c_H_SYNC,
   parameter int BP_LEN   = c_H_BP,
   parameter int ACT_LEN  = c_H_ACTIVE,
   parameter int FP_LEN   = c_H_FP,
   parameter bit POL      = 1'b0,
   parameter int POS_W    = width_of(ACT_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   output logic             sync,
   output logic             active,
   output logic [POS_W-1:0] pos,
   output logic             wrap
);

   localparam int              c_TOTAL    = SYNC_LEN + BP_LEN + ACT_LEN + FP_LEN;
   localparam int              c_CW       = width_of(c_TOTAL);
   localparam logic [c_CW-1:0] c_SYNC_END = c_CW'(SYNC_LEN - 1);
   localparam logic [c_CW-1:0] c_BP_END   = c_CW'(SYNC_LEN + BP_LEN - 1);
   localparam logic [c_CW-1:0] c_ACT_END  = c_CW'(SYNC_LEN + BP_LEN + ACT_LEN - 1);
   localparam logic [c_CW-1:0] c_LAST     = c_CW'(c_TOTAL - 1);
   localparam logic [c_CW-1:0] c_OFFSET   = c_CW'(SYNC_LEN + BP_LEN);

   phase_t             r_state;
   phase_t             w_state_nxt;
   logic [c_CW-1:0]    r_cnt;
   logic [c_CW-1:0]    w_cnt_nxt;
   logic               r_sync;
   logic               r_active;
   logic [POS_W-1:0]   r_pos;
   logic               w_sync_nxt;
   logic               w_active_nxt;
   logic [POS_W-1:0]   w_pos_nxt;

   assign wrap   = step && (r_cnt == c_LAST);
   assign sync   = r_sync;
   assign active = r_active;
   assign pos    = r_pos;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= SYNC;
         r_cnt    <= '0;
         r_sync   <= POL;
         r_active <= 1'b0;
         r_pos    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_sync   <= w_sync_nxt;
         r_active <= w_active_nxt;
         r_pos    <= w_pos_nxt;
      end
   end

   // Outputs are decoded from the next state so they land with the counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (step) begin
         w_cnt_nxt = (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
         case (r_state)
            SYNC:        if (r_cnt == c_SYNC_END) w_state_nxt = BACK_PORCH;
            BACK_PORCH:  if (r_cnt == c_BP_END)   w_state_nxt = DISPLAY;
            DISPLAY:     if (r_cnt == c_ACT_END)  w_state_nxt = FRONT_PORCH;
            FRONT_PORCH: if (r_cnt == c_LAST)     w_state_nxt = SYNC;
            default:                              w_state_nxt = SYNC;
         endcase
      end
      w_sync_nxt   = (w_state_nxt == SYNC) ? POL : ~POL;
      w_active_nxt = (w_state_nxt == DISPLAY);
      w_pos_nxt    = w_active_nxt ? POS_W'(w_cnt_nxt - c_OFFSET) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA sync/blanking generator with pixel-clock divider, frame
//               coordinates and line/frame start pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = c_H_ACTIVE,
   parameter int H_FP     = c_H_FP,
   parameter int H_SYNC   = c_H_SYNC,
   parameter int H_BP     = c_H_BP,
   parameter int V_ACTIVE = c_V_ACTIVE,
   parameter int V_FP     = c_V_FP,
   parameter int V_SYNC   = c_V_SYNC,
   parameter int V_BP     = c_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int PIX_DIV  = c_PIX_DIV
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          video_on,
   output logic [width_of(H_ACTIVE)-1:0] pixel_x,
   output logic [width_of(V_ACTIVE)-1:0] pixel_y,
   output logic                          pix_tick,
   output logic                          line_start,
   output logic                          frame_start
);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIX_DIV < 1) begin : g_bad_param
      $error("vga_timing_gen: every timing parameter must be at least 1");
   end

   localparam int              c_DW       = width_of(PIX_DIV);
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PIX_DIV - 1);

   logic [c_DW-1:0] r_div;
   logic            w_tick;
   logic            w_h_wrap;
   logic            w_v_wrap;
   logic            w_h_active;
   logic            w_v_active;
   logic            r_line_start;
   logic            r_frame_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div         <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         if (enable) begin
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
         end
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
      end
   end

   assign w_tick = enable && (r_div == c_DIV_LAST);

   vga_axis_fsm #(
      .SYNC_LEN (H_SYNC),
      .BP_LEN   (H_BP),
      .ACT_LEN  (H_ACTIVE),
      .FP_LEN   (H_FP),
      .POL      (H_POL),
      .POS_W    (width_of(H_ACTIVE))
   ) u_h_axis (
      .clk    (clk),
      .reset  (reset),
      .step   (w_tick),
      .sync   (hsync),
      .active (w_h_active),
      .pos    (pixel_x),
      .wrap   (w_h_wrap)
   );

   vga_axis_fsm #(
      .SYNC_LEN (V_SYNC),
      .BP_LEN   (V_BP),
      .ACT_LEN  (V_ACTIVE),
      .FP_LEN   (V_FP),
      .POL      (V_POL),
      .POS_W    (width_of(V_ACTIVE))
   ) u_v_axis (
      .clk    (clk),
      .reset  (reset),
      .step   (w_tick && w_h_wrap),
      .sync   (vsync),
      .active (w_v_active),
      .pos    (pixel_y),
      .wrap   (w_v_wrap)
   );

   assign video_on = w_h_active && w_v_active;

   // Pulses are qualified so a freeze or reset never shows a stale pulse.
   assign pix_tick    = w_tick && !reset;
   assign line_start  = r_line_start && enable;
   assign frame_start = r_frame_start && enable;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench: a small 16x7-line config checked cycle by
//               cycle plus a default 640x480 instance checked over two lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic en_s  = 1'b1;
   logic en_d  = 1'b1;

   logic       s_hsync, s_vsync, s_video_on, s_pix_tick, s_line_start, s_frame_start;
   logic [2:0] s_pixel_x;
   logic [1:0] s_pixel_y;
   logic       d_hsync, d_vsync, d_video_on, d_pix_tick, d_line_start, d_frame_start;
   logic [9:0] d_pixel_x;
   logic [8:0] d_pixel_y;

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (4), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .H_POL (1'b1), .V_POL (1'b1), .PIX_DIV (1)
   ) dut_s (
      .clk (clk), .reset (reset), .enable (en_s),
      .hsync (s_hsync), .vsync (s_vsync), .video_on (s_video_on),
      .pixel_x (s_pixel_x), .pixel_y (s_pixel_y), .pix_tick (s_pix_tick),
      .line_start (s_line_start), .frame_start (s_frame_start)
   );

   vga_timing_gen dut_d (
      .clk (clk), .reset (reset), .enable (en_d),
      .hsync (d_hsync), .vsync (d_vsync), .video_on (d_video_on),
      .pixel_x (d_pixel_x), .pixel_y (d_pixel_y), .pix_tick (d_pix_tick),
      .line_start (d_line_start), .frame_start (d_frame_start)
   );

   int tests = 0;
   int fails = 0;
   int cur_t = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s t=%0d: observed %0d expected %0d", tag, cur_t, obs, exp);
      end
   endtask

   // Small config: line = 16 clks (sync 0-3, bp 4-5, display 6-13, fp 14-15),
   // frame = 7 lines (sync 0, bp 1, display 2-5, fp 6); t = enabled edges since reset.
   task automatic chk_small(input int t);
      int h, v;
      bit hd, vd;
      h  = t % 16;
      v  = (t / 16) % 7;
      hd = (h >= 6) && (h <= 13);
      vd = (v >= 2) && (v <= 5);
      cur_t = t;
      chk("s_hsync",       32'(s_hsync),       32'(h < 4));
      chk("s_vsync",       32'(s_vsync),       32'(v < 1));
      chk("s_video_on",    32'(s_video_on),    32'(hd && vd));
      chk("s_pixel_x",     32'(s_pixel_x),     hd ? 32'(h - 6) : 32'd0);
      chk("s_pixel_y",     32'(s_pixel_y),     vd ? 32'(v - 2) : 32'd0);
      chk("s_pix_tick",    32'(s_pix_tick),    32'd1);
      chk("s_line_start",  32'(s_line_start),  32'(t > 0 && h == 0));
      chk("s_frame_start", 32'(s_frame_start), 32'(t > 0 && h == 0 && v == 0));
   endtask

   task automatic step_small(inout int ts);
      @(posedge clk);
      #1;
      ts++;
      chk_small(ts);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ts;
      int d_hs_low   = 0;
      int d_first_ls = -1;
      int d_ls_cnt   = 0;
      int d_fs_cnt   = 0;
      int d_vid_cnt  = 0;
      int d_tick_cnt = 0;

      // Reset state, sampled while reset is held.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_hsync",  32'(s_hsync),       32'd1);
      chk("rst_s_vsync",  32'(s_vsync),       32'd1);
      chk("rst_s_video",  32'(s_video_on),    32'd0);
      chk("rst_s_px",     32'(s_pixel_x),     32'd0);
      chk("rst_s_py",     32'(s_pixel_y),     32'd0);
      chk("rst_s_tick",   32'(s_pix_tick),    32'd0);
      chk("rst_s_ls",     32'(s_line_start),  32'd0);
      chk("rst_s_fs",     32'(s_frame_start), 32'd0);
      chk("rst_d_hsync",  32'(d_hsync),       32'd0);
      chk("rst_d_vsync",  32'(d_vsync),       32'd0);
      chk("rst_d_tick",   32'(d_pix_tick),    32'd0);

      reset = 1'b0;
      #1;
      // Default config: hsync low 384 of 3200 clks, line_start every 3200,
      // vsync low for the first two lines (6400 clks), no video this early.
      for (int t = 0; t <= 6400; t++) begin
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         if (t <= 230) chk_small(t);
         cur_t = t;
         if (t < 3200 && d_hsync == 1'b0) d_hs_low++;
         if (d_line_start) begin
            d_ls_cnt++;
            if (d_first_ls < 0) d_first_ls = t;
         end
         if (d_frame_start) d_fs_cnt++;
         if (d_video_on) d_vid_cnt++;
         if (t < 6400 && d_pix_tick) d_tick_cnt++;
         if (t == 6399) chk("d_vsync_in_sync", 32'(d_vsync), 32'd0);
         if (t == 6400) chk("d_vsync_after_sync", 32'(d_vsync), 32'd1);
      end
      chk("d_hsync_low_clks", 32'(d_hs_low),   32'd384);
      chk("d_first_ls",       32'(d_first_ls), 32'd3200);
      chk("d_ls_count",       32'(d_ls_cnt),   32'd2);
      chk("d_fs_count",       32'(d_fs_cnt),   32'd0);
      chk("d_video_count",    32'(d_vid_cnt),  32'd0);
      chk("d_tick_count",     32'(d_tick_cnt), 32'd1600);
      chk("d_pixel_x",        32'(d_pixel_x),  32'd0);
      chk("d_pixel_y",        32'(d_pixel_y),  32'd0);

      // Freeze mid-display at column 3, row 1 for 50 clks.
      ts = 6400;
      while (ts % 112 != 57) step_small(ts);
      en_s = 1'b0;
      #1;
      chk("frz_tick_now", 32'(s_pix_tick), 32'd0);
      repeat (50) begin
         @(posedge clk);
         #1;
         chk("frz_tick", 32'(s_pix_tick),    32'd0);
         chk("frz_ls",   32'(s_line_start),  32'd0);
         chk("frz_fs",   32'(s_frame_start), 32'd0);
      end
      chk("frz_hsync", 32'(s_hsync),    32'd0);
      chk("frz_vsync", 32'(s_vsync),    32'd0);
      chk("frz_video", 32'(s_video_on), 32'd1);
      chk("frz_px",    32'(s_pixel_x),  32'd3);
      chk("frz_py",    32'(s_pixel_y),  32'd1);
      en_s = 1'b1;
      #1;
      chk_small(ts);
      repeat (120) step_small(ts);

      // Reset mid-frame at column 5, row 2; next frame_start a full frame later.
      while (ts % 112 != 75) step_small(ts);
      chk("pre_rst_px", 32'(s_pixel_x), 32'd5);
      chk("pre_rst_py", 32'(s_pixel_y), 32'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_hsync", 32'(s_hsync),       32'd1);
      chk("mid_rst_vsync", 32'(s_vsync),       32'd1);
      chk("mid_rst_video", 32'(s_video_on),    32'd0);
      chk("mid_rst_px",    32'(s_pixel_x),     32'd0);
      chk("mid_rst_py",    32'(s_pixel_y),     32'd0);
      chk("mid_rst_tick",  32'(s_pix_tick),    32'd0);
      chk("mid_rst_ls",    32'(s_line_start),  32'd0);
      chk("mid_rst_fs",    32'(s_frame_start), 32'd0);
      reset = 1'b0;
      #1;
      ts = 0;
      chk_small(ts);
      repeat (115) step_small(ts);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
